// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory master.
package data_mem_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned WIDX_W         = ADDR_W - 2;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned LANE_W         = 2;
  localparam int unsigned STATE_W        = 3;
  localparam int unsigned DATA_MEM_DEPTH = 140001;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_MERGE = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // Request attributes kept for the duration of one transaction.
  typedef struct packed {
    logic              we;
    logic              is_byte;
    logic [LANE_W-1:0] lane;
    logic [BYTE_W-1:0] wbyte;
  } req_attr_t;

endpackage

// File: rtl/byte_lane_merge.sv
// Byte-lane extract (zero-extended) and insert on a 32-bit little-endian word.
// Only built when DATA_MEM_BYTE_RMW_EN is defined.
`ifdef DATA_MEM_BYTE_RMW_EN
module byte_lane_merge
  import data_mem_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [LANE_W-1:0] i_lane,
  input  logic [BYTE_W-1:0] i_byte,
  output logic [WORD_W-1:0] o_extract,
  output logic [WORD_W-1:0] o_insert
);

  logic [BYTE_W-1:0] w_lane_byte;

  // Lane 0 is bits [7:0]; the lane index selects an 8-bit slice.
  always_comb begin
    w_lane_byte = i_word[{i_lane, 3'b000} +: BYTE_W];
    o_extract   = WORD_W'(w_lane_byte);
    o_insert    = i_word;
    o_insert[{i_lane, 3'b000} +: BYTE_W] = i_byte;
  end

endmodule
`endif

// File: rtl/data_mem_master.sv
// Data-memory master: byte-addressed valid/ready requests to a word-addressed,
// 1-cycle read-first BRAM port, with a held valid/ready response channel.
// Optional feature macro: DATA_MEM_BYTE_RMW_EN (byte loads and read-modify-write
// byte stores). Without it every byte request is answered with an error.
module data_mem_master
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH = DATA_MEM_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_di,
  input  logic [WORD_W-1:0] mem_dout
);

  state_e            r_state;
  state_e            w_state_nxt;
  req_attr_t         r_attr;

  logic              r_req_ready;
  logic              r_resp_valid;
  logic [WORD_W-1:0] r_resp_rdata;
  logic              r_resp_err;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_di;

  logic              w_req_ready_d;
  logic              w_resp_valid_d;
  logic [WORD_W-1:0] w_resp_rdata_d;
  logic              w_resp_err_d;
  logic              w_mem_en_d;
  logic              w_mem_we_d;
  logic [ADDR_W-1:0] w_mem_addr_d;
  logic [WORD_W-1:0] w_mem_di_d;

  logic              w_accept;
  logic              w_req_err;
  logic              w_issue_done;
  logic              w_wait_merge;
  logic              w_resp_done;
  logic [WORD_W-1:0] w_load_data;

  assign w_accept    = (r_state == ST_IDLE) && req_valid && r_req_ready;
  assign w_resp_done = r_resp_valid && resp_ready;

`ifdef DATA_MEM_BYTE_RMW_EN
  logic [WORD_W-1:0] w_extract;
  logic [WORD_W-1:0] w_insert;

  byte_lane_merge u_byte_lane_merge (
    .i_word    (mem_dout),
    .i_lane    (r_attr.lane),
    .i_byte    (r_attr.wbyte),
    .o_extract (w_extract),
    .o_insert  (w_insert)
  );

  assign w_req_err    = (!req_byte && (req_addr[1:0] != 2'b00)) ||
                        (req_addr[ADDR_W-1:2] >= WIDX_W'(DEPTH));
  assign w_issue_done = r_attr.we && !r_attr.is_byte;
  assign w_wait_merge = r_attr.we && r_attr.is_byte;
  assign w_load_data  = r_attr.is_byte ? w_extract : mem_dout;
`else
  assign w_req_err    = req_byte || (req_addr[1:0] != 2'b00) ||
                        (req_addr[ADDR_W-1:2] >= WIDX_W'(DEPTH));
  assign w_issue_done = r_attr.we;
  assign w_wait_merge = 1'b0;
  assign w_load_data  = mem_dout;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = w_req_err ? ST_RESP : ST_ISSUE;
      ST_ISSUE: w_state_nxt = w_issue_done ? ST_RESP : ST_WAIT;
      ST_WAIT:  w_state_nxt = w_wait_merge ? ST_MERGE : ST_RESP;
`ifdef DATA_MEM_BYTE_RMW_EN
      ST_MERGE: w_state_nxt = ST_RESP;
`endif
      ST_RESP:  if (w_resp_done) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; each state sets what the following cycle shows.
  always_comb begin
    w_req_ready_d  = r_req_ready;
    w_resp_valid_d = r_resp_valid;
    w_resp_rdata_d = r_resp_rdata;
    w_resp_err_d   = r_resp_err;
    w_mem_en_d     = r_mem_en;
    w_mem_we_d     = r_mem_we;
    w_mem_addr_d   = r_mem_addr;
    w_mem_di_d     = r_mem_di;
    case (r_state)
      ST_IDLE: begin
        w_req_ready_d = 1'b1;
        if (w_accept) begin
          w_req_ready_d = 1'b0;
          if (w_req_err) begin
            w_resp_valid_d = 1'b1;
            w_resp_err_d   = 1'b1;
            w_resp_rdata_d = '0;
          end else begin
            w_mem_en_d   = 1'b1;
            w_mem_we_d   = req_we && !req_byte;
            w_mem_addr_d = {2'b00, req_addr[ADDR_W-1:2]};
            w_mem_di_d   = req_wdata;
          end
        end
      end
      ST_ISSUE: begin
        w_mem_en_d = 1'b0;
        w_mem_we_d = 1'b0;
        if (w_issue_done) begin
          w_resp_valid_d = 1'b1;
          w_resp_err_d   = 1'b0;
          w_resp_rdata_d = '0;
        end
      end
      ST_WAIT: begin
`ifdef DATA_MEM_BYTE_RMW_EN
        if (w_wait_merge) begin
          w_mem_en_d = 1'b1;
          w_mem_we_d = 1'b1;
          w_mem_di_d = w_insert;
        end else begin
          w_resp_valid_d = 1'b1;
          w_resp_err_d   = 1'b0;
          w_resp_rdata_d = w_load_data;
        end
`else
        w_resp_valid_d = 1'b1;
        w_resp_err_d   = 1'b0;
        w_resp_rdata_d = w_load_data;
`endif
      end
`ifdef DATA_MEM_BYTE_RMW_EN
      ST_MERGE: begin
        w_mem_en_d     = 1'b0;
        w_mem_we_d     = 1'b0;
        w_resp_valid_d = 1'b1;
        w_resp_err_d   = 1'b0;
        w_resp_rdata_d = '0;
      end
`endif
      ST_RESP: begin
        if (w_resp_done) begin
          w_resp_valid_d = 1'b0;
          w_resp_err_d   = 1'b0;
          w_resp_rdata_d = '0;
          w_req_ready_d  = 1'b1;
        end
      end
      default: begin
        w_mem_en_d = 1'b0;
        w_mem_we_d = 1'b0;
      end
    endcase
  end

  // Output registers; all cleared while in reset so the BRAM is never left enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_di     <= '0;
    end else begin
      r_req_ready  <= w_req_ready_d;
      r_resp_valid <= w_resp_valid_d;
      r_resp_rdata <= w_resp_rdata_d;
      r_resp_err   <= w_resp_err_d;
      r_mem_en     <= w_mem_en_d;
      r_mem_we     <= w_mem_we_d;
      r_mem_addr   <= w_mem_addr_d;
      r_mem_di     <= w_mem_di_d;
    end
  end

  // Request attributes latched at the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_attr <= '0;
    end else if (w_accept) begin
      r_attr.we      <= req_we;
      r_attr.is_byte <= req_byte;
      r_attr.lane    <= req_addr[LANE_W-1:0];
      r_attr.wbyte   <= req_wdata[BYTE_W-1:0];
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_di     = r_mem_di;

endmodule

// File: tb/tb_data_mem_master.sv
// Bench for data_mem_master with a 1-cycle read-first BRAM model.
module tb_data_mem_master;

  localparam int unsigned DEPTH = 140001;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_byte = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_di;
  logic [31:0] mem_dout = '0;

  int checks = 0;
  int errors = 0;
  int en_cycles = 0;
  logic bad_addr = 1'b0;

  logic [31:0] bram [0:DEPTH-1];
  logic [31:0] ref_mem [int unsigned];

  data_mem_master #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // BRAM model: read-first, data on mem_dout the cycle after the enabled edge.
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      en_cycles <= en_cycles + 1;
      if (mem_addr < DEPTH) begin
        mem_dout <= bram[mem_addr];
        if (mem_we === 1'b1) bram[mem_addr] <= mem_di;
      end else begin
        bad_addr <= 1'b1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, " req_ready"},  32'(req_ready),  32'd0);
    chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, " resp_rdata"}, resp_rdata,      32'd0);
    chk({tag, " resp_err"},   32'(resp_err),   32'd0);
    chk({tag, " mem_en"},     32'(mem_en),     32'd0);
    chk({tag, " mem_we"},     32'(mem_we),     32'd0);
    chk({tag, " mem_addr"},   mem_addr,        32'd0);
    chk({tag, " mem_di"},     mem_di,          32'd0);
  endtask

  // Reference model: applies one request to the word store and returns the expected response.
  task automatic ref_op(input logic we, input logic bt, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic err, output logic [31:0] rdata);
    int unsigned idx;
    int unsigned lane;
    logic [31:0] w;
    idx  = addr >> 2;
    lane = addr & 32'd3;
    err  = (idx >= DEPTH) || (!bt && lane != 0);
`ifndef DATA_MEM_BYTE_RMW_EN
    if (bt) err = 1'b1;
`endif
    rdata = '0;
    if (!err) begin
      w = ref_mem.exists(idx) ? ref_mem[idx] : 32'd0;
      if (we && bt) begin
        w[lane*8 +: 8] = wdata[7:0];
        ref_mem[idx]   = w;
      end else if (we) begin
        ref_mem[idx] = wdata;
      end else if (bt) begin
        rdata = (w >> (lane * 8)) & 32'hFF;
      end else begin
        rdata = w;
      end
    end
  endtask

  function automatic int exp_latency(input logic we, input logic bt, input logic err);
    if (err) return 1;
    if (we && bt) return 4;
    if (we) return 2;
    return 3;
  endfunction

  // One full transaction: handshake, latency, response, backpressure, completion.
  task automatic do_op(input string name, input logic we, input logic bt, input logic [31:0] addr,
                       input logic [31:0] wdata, input int delay, input logic exp_err,
                       input logic [31:0] exp_rdata, input int exp_lat);
    int n;
    int en0;
    int exp_en;
    logic busy_ok;
    logic stable;
    logic [31:0] hold_rdata;
    logic hold_err;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, " ready wait"}, 32'(n), 32'd0);
    req_valid = 1'b1;
    req_we    = we;
    req_byte  = bt;
    req_addr  = addr;
    req_wdata = wdata;
    en0 = en_cycles;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'($urandom_range(0, 1));
    req_we    = 1'($urandom_range(0, 1));
    req_byte  = 1'($urandom_range(0, 1));
    req_addr  = $urandom;
    req_wdata = $urandom;
    n = 1;
    busy_ok = 1'b1;
    while (resp_valid !== 1'b1 && n < 20) begin
      if (req_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk({name, " latency"}, 32'(n), 32'(exp_lat));
    chk({name, " resp_err"}, 32'(resp_err), 32'(exp_err));
    chk({name, " resp_rdata"}, resp_rdata, exp_rdata);
    hold_rdata = resp_rdata;
    hold_err   = resp_err;
    stable = 1'b1;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== hold_rdata || resp_err !== hold_err ||
          req_ready !== 1'b0) stable = 1'b0;
    end
    chk({name, " busy req_ready low"}, 32'(busy_ok), 32'd1);
    chk({name, " held response"}, 32'(stable), 32'd1);
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(negedge clk);
    resp_ready = 1'b0;
    chk({name, " resp_valid after done"}, 32'(resp_valid), 32'd0);
    chk({name, " req_ready after done"}, 32'(req_ready), 32'd1);
    exp_en = exp_err ? 0 : ((we && bt) ? 2 : 1);
    chk({name, " bram enables"}, 32'(en_cycles - en0), 32'(exp_en));
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic        bt;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic        err;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input logic we, input logic bt, input logic [31:0] addr,
                     input logic [31:0] wdata, input int delay, input logic err,
                     input logic [31:0] rdata, input int lat);
    vec_t v;
    v.name = name; v.we = we; v.bt = bt; v.addr = addr; v.wdata = wdata;
    v.delay = delay; v.err = err; v.rdata = rdata; v.lat = lat;
    tbl.push_back(v);
  endtask

  initial begin
    logic        m_err;
    logic [31:0] m_rdata;
    logic        we;
    logic        bt;
    int unsigned idx;
    int unsigned lane;
    int unsigned sel;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] w;

    for (int i = 0; i < int'(DEPTH); i++) bram[i] = '0;

    add("st word 0x40",     1, 0, 32'h40,           32'hDEADBEEF, 0, 0, 32'h0,        2);
    add("ld word 0x40",     0, 0, 32'h40,           32'h0,        0, 0, 32'hDEADBEEF, 3);
    add("ld misaligned",    0, 0, 32'h42,           32'h0,        0, 1, 32'h0,        1);
    add("ld DEPTH*4",       0, 0, DEPTH * 4,        32'h0,        0, 1, 32'h0,        1);
    add("ld last word",     0, 0, (DEPTH - 1) * 4,  32'h0,        0, 0, 32'h0,        3);
    add("st last word",     1, 0, (DEPTH - 1) * 4,  32'hCAFEF00D, 1, 0, 32'h0,        2);
    add("ld last word 2",   0, 0, (DEPTH - 1) * 4,  32'h0,        0, 0, 32'hCAFEF00D, 3);
    add("ld held 5",        0, 0, 32'h40,           32'h0,        5, 0, 32'hDEADBEEF, 3);
    add("st word 0x80",     1, 0, 32'h80,           32'h11223344, 0, 0, 32'h0,        2);
`ifdef DATA_MEM_BYTE_RMW_EN
    add("st byte 0x81",     1, 1, 32'h81,           32'h000000AA, 0, 0, 32'h0,        4);
    add("ld word 0x80 rmw", 0, 0, 32'h80,           32'h0,        0, 0, 32'h1122AA44, 3);
    add("ld byte 0x83",     0, 1, 32'h83,           32'h0,        2, 0, 32'h00000011, 3);
    add("ld byte 0x80",     0, 1, 32'h80,           32'h0,        0, 0, 32'h00000044, 3);
    add("st byte 0x83",     1, 1, 32'h83,           32'hFFFFFFBB, 3, 0, 32'h0,        4);
    add("ld word 0x80 b3",  0, 0, 32'h80,           32'h0,        0, 0, 32'hBB22AA44, 3);
`else
    add("st byte 0x81",     1, 1, 32'h81,           32'h000000AA, 0, 1, 32'h0,        1);
    add("ld word 0x80",     0, 0, 32'h80,           32'h0,        0, 0, 32'h11223344, 3);
    add("ld byte 0x83",     0, 1, 32'h83,           32'h0,        2, 1, 32'h0,        1);
`endif
    add("st misaligned",    1, 0, 32'h86,           32'h99999999, 0, 1, 32'h0,        1);
    add("ld untouched",     0, 0, 32'h84,           32'h0,        0, 0, 32'h0,        3);
    add("st out of range",  1, 0, DEPTH * 4 + 8,    32'h77777777, 2, 1, 32'h0,        1);

    // Reset state and release.
    repeat (3) @(negedge clk);
    chk_outs_zero("reset");
    rst = 1'b0;
    #1;
    chk("req_ready at release", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("req_ready after release", 32'(req_ready), 32'd1);

    // Directed vectors.
    foreach (tbl[i]) begin
      ref_op(tbl[i].we, tbl[i].bt, tbl[i].addr, tbl[i].wdata, m_err, m_rdata);
      do_op(tbl[i].name, tbl[i].we, tbl[i].bt, tbl[i].addr, tbl[i].wdata, tbl[i].delay,
            tbl[i].err, tbl[i].rdata, tbl[i].lat);
    end

    // Reset while a store is in ISSUE.
    ref_op(1'b1, 1'b0, 32'h100, 32'h12345678, m_err, m_rdata);
    do_op("st old 0x100", 1'b1, 1'b0, 32'h100, 32'h12345678, 0, 1'b0, 32'h0, 2);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h55AA55AA;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst test mem_en in ISSUE", 32'(mem_en), 32'd1);
    rst = 1'b1;
    #1;
    chk_outs_zero("mid-store reset");
    repeat (2) @(negedge clk);
    w = bram[64];
    chk("store old or new only", 32'((w == 32'h12345678) || (w == 32'h55AA55AA)), 32'd1);
    rst = 1'b0;
    #1;
    chk("req_ready at release 2", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("req_ready after release 2", 32'(req_ready), 32'd1);
    ref_op(1'b1, 1'b0, 32'h100, 32'h0BADF00D, m_err, m_rdata);
    do_op("st resync 0x100", 1'b1, 1'b0, 32'h100, 32'h0BADF00D, 0, 1'b0, 32'h0, 2);
    ref_op(1'b0, 1'b0, 32'h100, 32'h0, m_err, m_rdata);
    do_op("ld resync 0x100", 1'b0, 1'b0, 32'h100, 32'h0, 1, m_err, m_rdata, 3);

    // Random mix against the reference model.
    for (int i = 0; i < 1000; i++) begin
      we  = 1'($urandom_range(0, 1));
      bt  = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 19);
      if (sel < 14)      idx = $urandom_range(0, 63);
      else if (sel < 17) idx = $urandom_range(DEPTH - 2, DEPTH + 1);
      else               idx = $urandom >> 2;
      if (bt || $urandom_range(0, 4) == 0) lane = $urandom_range(0, 3);
      else                                 lane = 0;
      a  = 32'(idx << 2) | 32'(lane);
      wd = $urandom;
      ref_op(we, bt, a, wd, m_err, m_rdata);
      do_op($sformatf("rand%0d", i), we, bt, a, wd, $urandom_range(0, 3), m_err, m_rdata,
            exp_latency(we, bt, m_err));
    end

    // Final memory image against the model.
    foreach (ref_mem[k]) chk($sformatf("mem word %0d", k), bram[k], ref_mem[k]);
    chk("no out-of-range bram access", 32'(bad_addr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
